// File: rtl/fpadd_vec_seq_if.sv
// Bus between the FP-adder test sequencer and its host/adder side.
// The master drives vector loads, start and the adder result; the slave is the sequencer.
interface fpadd_vec_seq_if #(
  parameter int AW = 4
);
  logic          vec_we;
  logic [AW-1:0] vec_addr;
  logic [95:0]   vec_data;
  logic          start;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [31:0]   fp_sum;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_idx;

  modport master (
    output vec_we, vec_addr, vec_data, start, fp_sum,
    input  op_a, op_b, busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    input  vec_we, vec_addr, vec_data, start, fp_sum,
    output op_a, op_b, busy, done, pass, err_count, first_err_idx
  );
endinterface

// File: rtl/fpadd_vec_seq.sv
// Vector sequencer for fpadd_single: issues {A,B}, waits LATENCY, checks out bit-exactly.
// Optional build macro FPADD_SEQ_STOP_ON_ERR_EN ends the run at the first mismatch.
module fpadd_vec_seq #(
  parameter int NUM     = 10,
  parameter int AW      = 4,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  fpadd_vec_seq_if.slave  bus
);

  localparam int WW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
`ifdef FPADD_SEQ_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t        state, state_d;
  vec_t          mem [2**AW];
  logic [AW-1:0] idx;
  logic [WW-1:0] wcnt;
  logic [31:0]   exp_q, op_a_q, op_b_q;
  logic [15:0]   err_q;
  logic [AW-1:0] fei_q;
  logic          done_q;
  logic          idle_like, accept, mism, last;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign accept    = idle_like && bus.start;
  assign mism      = (bus.fp_sum != exp_q);
  assign last      = (idx == AW'(NUM - 1));

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else        state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: if (bus.start) state_d = S_ISSUE;
      S_ISSUE:        state_d = S_WAIT;
      S_WAIT:         if (wcnt == WW'(LATENCY - 1)) state_d = S_CHECK;
      S_CHECK:        state_d = (last || (STOP_ON_ERR && mism)) ? S_DONE : S_ISSUE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Table is deliberately outside reset so a reloaded regression survives a reset.
  always_ff @(posedge clk)
    if (idle_like && bus.vec_we && (int'(bus.vec_addr) < NUM))
      mem[bus.vec_addr] <= bus.vec_data;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx    <= '0;
      wcnt   <= '0;
      exp_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      err_q  <= '0;
      fei_q  <= '1;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        idx    <= '0;
        err_q  <= '0;
        fei_q  <= '1;
        done_q <= 1'b0;
      end else if (state == S_DONE) begin
        done_q <= 1'b1;
      end
      case (state)
        S_ISSUE: begin
          op_a_q <= mem[idx].a;
          op_b_q <= mem[idx].b;
          exp_q  <= mem[idx].exp;
          wcnt   <= '0;
        end
        S_WAIT: wcnt <= wcnt + 1'b1;
        S_CHECK: begin
          if (mism) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (fei_q == '1)       fei_q <= idx;
          end
          if (!last && !(STOP_ON_ERR && mism)) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end

  assign bus.op_a          = op_a_q;
  assign bus.op_b          = op_b_q;
  assign bus.busy          = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
  assign bus.done          = done_q;
  assign bus.pass          = done_q && (err_q == 16'd0);
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = fei_q;

endmodule

// File: doc/fpadd_vec_seq.md
# fpadd_vec_seq

On-board stimulus/check sequencer for the single-precision FP adder. It holds a table of `{A, B, expected}` vectors and drives each operand pair into `fpadd_single`. It waits out the adder latency, compares the adder's `out` bit-exactly against the expected word, and reports the error count and pass/fail. It sits directly upstream of the adder, feeding `reg_A`/`reg_B`, and directly downstream of it, consuming `out`, so the hex-vector regression can run on the Zedboard without a simulator.

## Interface
- `NUM`, 10: number of vectors, 1..2**AW.
- `AW`, 4: vector-table address width.
- `LATENCY`, 2: adder cycles from operands registered to `out` valid, ≥1.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted at 0). One clock.
- `vec_we`  in  1: vector-table write strobe; ignored while `busy`.
- `vec_addr`  in  AW: write address; writes to addresses ≥NUM are dropped.
- `vec_data`  in  96: `{A[95:64], B[63:32], expected[31:0]}`, same packing as `fp_InOut.hex`.
- `start`  in  1: single-cycle run request; accepted in IDLE or DONE only.
- `op_a`  out  32: to adder `reg_A`.
- `op_b`  out  32: to adder `reg_B`.
- `fp_sum`  in  32: from adder `out`.
- `busy`  out  1: run in progress.
- `done`  out  1: run finished; held until next accepted `start` or reset.
- `pass`  out  1: `done` and `err_count==0`.
- `err_count`  out  16: mismatches this run; saturates at 16'hFFFF.
- `first_err_idx`  out  AW: index of the first mismatch; all-ones if no mismatch.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE with `start`=1:
  - clear `idx`, `err_count`, `done`; set `first_err_idx` to all-ones.
  - go to ISSUE.
- ISSUE, 1 cycle: register `op_a<=mem[idx][95:64]`, `op_b<=mem[idx][63:32]`, `exp_q<=mem[idx][31:0]`; go to WAIT.
- WAIT: exactly LATENCY cycles, counted by `wcnt`; then go to CHECK.
- CHECK, 1 cycle: compare `fp_sum` against `exp_q`.
  - Compare is bitwise `!=`, with no NaN or ±0 equivalence.
  - On mismatch: `err_count` +1 (saturating). Load `first_err_idx<=idx` if it is still all-ones.
  - If `idx==NUM-1`, go to DONE. Otherwise `idx<=idx+1` and go to ISSUE.
- DONE: `done`=1, `busy`=0. `op_a`/`op_b` hold the last vector.
- `busy`=1 in ISSUE, WAIT and CHECK.
- `start` is ignored while `busy`.
- `vec_we` writes `mem[vec_addr]<=vec_data` in IDLE/DONE only.
- Simultaneous `vec_we` and `start` in IDLE: the write takes effect, and the run reads the table after the write. Both happen at the same edge, and ISSUE reads `mem` one cycle later.
- Table contents are not cleared by reset.

## Timing
- Reset values:
  - outputs: `op_a`, `op_b`, `err_count`=0; `busy`, `done`, `pass`=0; `first_err_idx`=all-ones.
  - internal: state IDLE; `idx`, `wcnt`, `exp_q`=0.
- Reset mid-run aborts immediately to IDLE with the values above. There is no partial result.
- `start` sampled high at edge E0 puts the block in ISSUE during cycle E0..E1.
- Vector k operands become visible on `op_a`/`op_b` at edge E1+k·(LATENCY+2).
- `fp_sum` is sampled at the edge ending CHECK, which is LATENCY+1 edges after the operands changed. This gives one cycle of margin past adder latency.
- Per-vector cost: LATENCY+2 cycles. The `done` rising edge arrives NUM·(LATENCY+2)+1 edges after the `start` edge.
- Counters update on the edge ending CHECK. `pass` is combinational from `done` and `err_count`.

## Configuration
- `FPADD_SEQ_STOP_ON_ERR_EN` defined:
  - the first mismatch in CHECK goes straight to DONE;
  - `err_count`=1, `first_err_idx`=failing index, and the remaining vectors are skipped.
- Not defined: all NUM vectors always run, and `err_count` is the total number of mismatches.

## Test plan
- Load 10 vectors and model the adder as exact (`fp_sum` = correct sum after 2 cycles). Then `start` → `done` at edge 41, `err_count`=0, `first_err_idx`=4'hF, `pass`=1.
- Vector 3 (3F800000+40000000, expected 40400000), with the model returning 40400001 → `err_count`=1, `first_err_idx`=3, `pass`=0. With `FPADD_SEQ_STOP_ON_ERR_EN`, `done` comes at edge 17.
- Check the `op_a`/`op_b` sequence: vector k appears at edge 1+4k and stays stable for 4 cycles. `start` pulsed during `busy` changes nothing.
- Assert `reset`=0 in the WAIT of vector 5 → all outputs return to reset values at once. A new `start` reruns from vector 0 and finishes with the correct totals.
- NUM=1, LATENCY=1: `done` at edge 4. `vec_we` to address 1 is dropped. `vec_we` while `busy` does not alter the table.
- Force 16'hFFFF mismatches by running 65540 failing checks over repeated `start`s without clearing: `err_count` saturates at 16'hFFFF. Because each `start` clears the counter, this requires an internal preload or a NUM=16 loop bench.
